// File: rtl/bias_load_ctrl_pkg.sv
// Shared constants, FSM encoding and helpers for the bias load controller.
package bias_load_ctrl_pkg;

  // Default widths
  localparam int unsigned DATA_BITS = 48;  // accumulator / bias output width
  localparam int unsigned BIAS_BITS = 16;  // stored bias width, two's complement
  localparam int unsigned SHIFT_W   = 5;   // shift amount width
  localparam int unsigned ADDR_W    = 10;  // bias buffer address width
  localparam int unsigned CNT_W     = 8;   // channel counter width

  // Legal shift window of the bias shifter
  localparam int unsigned SHIFT_MIN = 5;
  localparam int unsigned SHIFT_MAX = 25;

  // Controller states
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StCheck = 3'd1,
    StRd    = 3'd2,
    StCap   = 3'd3,
    StOut   = 3'd4,
    StDone  = 3'd5
  } state_e;

  // Inclusive range test shared by the controller and the shifter
  function automatic logic in_range(input int unsigned v, input int unsigned lo,
                                    input int unsigned hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/bias_load_ctrl_if.sv
// Bias SRAM read port plus the shifted-bias valid/ready stream.
interface bias_load_ctrl_if
  import bias_load_ctrl_pkg::*;
#(
  parameter int unsigned DataBits = DATA_BITS,
  parameter int unsigned BiasBits = BIAS_BITS,
  parameter int unsigned AddrW    = ADDR_W,
  parameter int unsigned CntW     = CNT_W
);

  // SRAM read port; data returns the cycle after mem_rd_en
  logic                mem_rd_en;
  logic [AddrW-1:0]    mem_rd_addr;
  logic [BiasBits-1:0] mem_rd_data;

  // Shifted bias stream towards the accumulator-init path
  logic                b_valid;
  logic                b_ready;
  logic [DataBits-1:0] b_data;
  logic [CntW-1:0]     b_idx;
  logic                b_last;

  // Controller side
  modport master (
    output mem_rd_en, mem_rd_addr, b_valid, b_data, b_idx, b_last,
    input  mem_rd_data, b_ready
  );

  // SRAM / consumer side
  modport slave (
    input  mem_rd_en, mem_rd_addr, b_valid, b_data, b_idx, b_last,
    output mem_rd_data, b_ready
  );

endinterface

// File: rtl/bias_load_ctrl_shifter.sv
// Bias shifter: arithmetic right shift (floor semantics) over the legal shift window.
module bias_load_ctrl_shifter
  import bias_load_ctrl_pkg::*;
#(
  parameter int unsigned DataBits = DATA_BITS,
  parameter int unsigned ShiftW   = SHIFT_W,
  parameter int unsigned ShiftMin = SHIFT_MIN,
  parameter int unsigned ShiftMax = SHIFT_MAX
) (
  input  logic [DataBits-1:0] data_i,
  input  logic [ShiftW-1:0]   shift_i,
  output logic [DataBits-1:0] data_o
);

  // Out-of-window amounts fall to zero; the controller never presents one
  always_comb begin
    data_o = '0;
    if (in_range(32'(shift_i), ShiftMin, ShiftMax)) begin
      data_o = $signed(data_i) >>> shift_i;
    end
  end

endmodule

// File: rtl/bias_load_ctrl.sv
// Per-layer bias loader: reads biases from SRAM, sign-extends, shifts and streams them.
module bias_load_ctrl
  import bias_load_ctrl_pkg::*;
#(
  parameter int unsigned DataBits = DATA_BITS,
  parameter int unsigned BiasBits = BIAS_BITS,
  parameter int unsigned ShiftW   = SHIFT_W,
  parameter int unsigned AddrW    = ADDR_W,
  parameter int unsigned CntW     = CNT_W,
  parameter int unsigned ShiftMin = SHIFT_MIN,
  parameter int unsigned ShiftMax = SHIFT_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [AddrW-1:0]  cfg_base_addr_i,
  input  logic [CntW-1:0]   cfg_num_ch_i,
  input  logic [ShiftW-1:0] cfg_n_shift_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  bias_load_ctrl_if.master  bus_io
);

  state_e state_q, state_d;

  // Latched run configuration
  logic [AddrW-1:0]    base_q, base_d;
  logic [CntW-1:0]     num_q, num_d;
  logic [ShiftW-1:0]   shift_q, shift_d;
  logic                err_q, err_d;

  // Channel index and output holding registers
  logic [CntW-1:0]     idx_q, idx_d;
  logic [DataBits-1:0] bdata_q, bdata_d;
  logic [CntW-1:0]     bidx_q, bidx_d;
  logic                blast_q, blast_d;

  logic                shift_ok;
  logic                handshake;
  logic [DataBits-1:0] bias_ext;
  logic [DataBits-1:0] bias_shifted;

  assign shift_ok  = in_range(32'(shift_q), ShiftMin, ShiftMax);
  assign handshake = (state_q == StOut) && bus_io.b_ready;

  // SRAM returns BiasBits; widen with the sign bit before shifting
  assign bias_ext = {{(DataBits - BiasBits){bus_io.mem_rd_data[BiasBits-1]}},
                     bus_io.mem_rd_data};

  bias_load_ctrl_shifter #(
    .DataBits (DataBits),
    .ShiftW   (ShiftW),
    .ShiftMin (ShiftMin),
    .ShiftMax (ShiftMax)
  ) u_shifter (
    .data_i  (bias_ext),
    .shift_i (shift_q),
    .data_o  (bias_shifted)
  );

  // State register; reset abandons any run in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = StCheck;
      end
      StCheck: begin
        if (!shift_ok) begin
          state_d = StDone;
        end else if (num_q == '0) begin
          state_d = StDone;
        end else begin
          state_d = StRd;
        end
      end
      StRd:  state_d = StCap;
      StCap: state_d = StOut;
      StOut: begin
        if (handshake) state_d = blast_q ? StDone : StRd;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode from the current state
  always_comb begin
    busy_o             = 1'b0;
    done_o             = 1'b0;
    err_o              = 1'b0;
    bus_io.mem_rd_en   = 1'b0;
    bus_io.mem_rd_addr = '0;
    bus_io.b_valid     = 1'b0;
    unique case (state_q)
      StIdle:  ;
      StCheck: busy_o = 1'b1;
      StRd: begin
        busy_o             = 1'b1;
        bus_io.mem_rd_en   = 1'b1;
        // Address wraps silently at the top of the buffer
        bus_io.mem_rd_addr = base_q + AddrW'(idx_q);
      end
      StCap:   busy_o = 1'b1;
      StOut: begin
        busy_o         = 1'b1;
        bus_io.b_valid = 1'b1;
      end
      StDone: begin
        done_o = 1'b1;
        err_o  = err_q;
      end
      default: ;
    endcase
  end

  assign bus_io.b_data = bdata_q;
  assign bus_io.b_idx  = bidx_q;
  assign bus_io.b_last = blast_q;

  // Datapath next-state: config latch, error flag, index and output capture
  always_comb begin
    base_d  = base_q;
    num_d   = num_q;
    shift_d = shift_q;
    err_d   = err_q;
    idx_d   = idx_q;
    bdata_d = bdata_q;
    bidx_d  = bidx_q;
    blast_d = blast_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          base_d  = cfg_base_addr_i;
          num_d   = cfg_num_ch_i;
          shift_d = cfg_n_shift_i;
          idx_d   = '0;
          err_d   = 1'b0;
        end
      end
      StCheck: err_d = !shift_ok;
      StCap: begin
        bdata_d = bias_shifted;
        bidx_d  = idx_q;
        blast_d = (idx_q == (num_q - CntW'(1)));
      end
      StOut: begin
        if (handshake && !blast_q) idx_d = idx_q + CntW'(1);
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q  <= '0;
      num_q   <= '0;
      shift_q <= '0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      bdata_q <= '0;
      bidx_q  <= '0;
      blast_q <= 1'b0;
    end else begin
      base_q  <= base_d;
      num_q   <= num_d;
      shift_q <= shift_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      bdata_q <= bdata_d;
      bidx_q  <= bidx_d;
      blast_q <= blast_d;
    end
  end

endmodule
